sc_spi_xfer_arb: RTL

//  SYSCLK-domain arbiter/sequencer sharing one SPI protocol engine between NREQ requesters.

---
 rtl/sc_spi_xfer_arb_pkg.sv | 20 ++
 rtl/sc_spi_rr_arb.sv | 29 ++
 rtl/sc_spi_xfer_arb.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sc_spi_xfer_arb_pkg.sv
// Shared types for the sc-spi transfer arbiter: sequencer states, default watchdog width
// and the round-robin pointer helper.
package sc_spi_xfer_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWbusy,
        StActive,
        StFlush,
        StFin
    } xfer_state_e;

    localparam int unsigned DefaultTow = 16;

    // Next round-robin pointer: one past the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sc_spi_rr_arb.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module sc_spi_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PTRW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PTRW-1:0] win_idx,
    output logic            win_vld
);

    always_comb begin
        int unsigned j;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr) + i) % NREQ;
            if (!win_vld && req[j]) begin
                win_vld    = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = PTRW'(j);
            end
        end
    end

endmodule

// File: rtl/sc_spi_xfer_arb.sv
// SYSCLK-domain arbiter/sequencer sharing one SPI engine among NREQ requesters.
// Optional transfer watchdog enabled by defining SC_SPI_XFER_ARB_WDT_EN.
module sc_spi_xfer_arb
    import sc_spi_xfer_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CNTW = 8,
    parameter int unsigned TOW  = DefaultTow
) (
    input  logic            SYSCLK,
    input  logic            SYSRST,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] GNT,
    output logic [NREQ-1:0] DONE,
    output logic            ERR,
    output logic [CNTW-1:0] RXCNT,
    input  logic [TOW-1:0]  TOVAL,
    output logic            CLKEN,
    input  logic            SPIBUSY_SYSCLK,
    input  logic            RXVALID_SYSCLK
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    xfer_state_e     state;
    logic [PTRW-1:0] ptr;
    logic [NREQ-1:0] win_oh;
    logic [PTRW-1:0] win_idx;
    logic            win_vld;
    logic [CNTW-1:0] rxcnt_inc;

    sc_spi_rr_arb #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_rr_arb (
        .req     (REQ),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign rxcnt_inc = (RXCNT == '1) ? RXCNT : RXCNT + CNTW'(1);

`ifdef SC_SPI_XFER_ARB_WDT_EN
    logic [TOW-1:0] wdt_q;
    logic [TOW-1:0] wdt_step;
    logic           wdt_hit;
    logic           err_q;

    // A counted RXVALID proves the engine is alive and restarts the timeout.
    always_comb begin
        wdt_step = wdt_q;
        if (state == StActive && RXVALID_SYSCLK) begin
            wdt_step = '0;
        end else if (wdt_q != '1) begin
            wdt_step = wdt_q + TOW'(1);
        end
    end

    assign wdt_hit = (TOVAL != '0) && (wdt_q == TOVAL);
    assign ERR     = err_q;
`else
    logic unused_toval;
    assign unused_toval = ^TOVAL;
    assign ERR          = 1'b0;
`endif

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            state <= StIdle;
            ptr   <= '0;
            GNT   <= '0;
            DONE  <= '0;
            RXCNT <= '0;
            CLKEN <= 1'b0;
`ifdef SC_SPI_XFER_ARB_WDT_EN
            wdt_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            DONE <= '0;
`ifdef SC_SPI_XFER_ARB_WDT_EN
            err_q <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    // Stale engine activity blocks new grants until busy reads low.
                    if (win_vld && !SPIBUSY_SYSCLK) begin
                        GNT   <= win_oh;
                        CLKEN <= 1'b1;
                        ptr   <= PTRW'(rr_next(32'(win_idx), NREQ));
                        RXCNT <= '0;
                        state <= StWbusy;
`ifdef SC_SPI_XFER_ARB_WDT_EN
                        wdt_q <= '0;
`endif
                    end
                end
                StWbusy: begin
`ifdef SC_SPI_XFER_ARB_WDT_EN
                    wdt_q <= wdt_step;
                    if (wdt_hit) begin
                        CLKEN <= 1'b0;
                        state <= StFlush;
                    end else
`endif
                    if (SPIBUSY_SYSCLK) begin
                        state <= StActive;
                    end
                end
                StActive: begin
                    if (RXVALID_SYSCLK) begin
                        RXCNT <= rxcnt_inc;
                    end
                    if (!SPIBUSY_SYSCLK) begin
                        CLKEN <= 1'b0;
                        DONE  <= GNT;
                        GNT   <= '0;
                        state <= StFin;
                    end
`ifdef SC_SPI_XFER_ARB_WDT_EN
                    else if (wdt_hit) begin
                        CLKEN <= 1'b0;
                        state <= StFlush;
                    end
                    wdt_q <= wdt_step;
`endif
                end
`ifdef SC_SPI_XFER_ARB_WDT_EN
                StFlush: begin
                    if (!SPIBUSY_SYSCLK) begin
                        DONE  <= GNT;
                        GNT   <= '0;
                        err_q <= 1'b1;
                        state <= StFin;
                    end
                end
`endif
                StFin: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
